iob_cnsl_responder: RTL

//  Native-bus responder: the SoC-side register file a console initiator polls and writes.

---
 rtl/iob_cnsl_responder_pkg.sv | 35 +++
 rtl/iob_cnsl_fifo.sv | 61 ++++++
 rtl/iob_cnsl_responder.sv | 106 ++++++++++
 3 files changed

// File: rtl/iob_cnsl_responder_pkg.sv
// +----------------------------------------------------------------------------+
// | iob_cnsl_responder_pkg                                                     |
// | Register map and STATUS field layout shared by the console responder.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package iob_cnsl_responder_pkg;

  localparam int unsigned REG_TXDATA    = 0;
  localparam int unsigned REG_RXDATA    = 1;
  localparam int unsigned REG_TXREADY   = 2;
  localparam int unsigned REG_RXREADY   = 3;
  localparam int unsigned REG_SOFTRESET = 4;
  localparam int unsigned REG_STATUS    = 5;

  localparam int unsigned STATUS_TX_LSB  = 0;
  localparam int unsigned STATUS_RX_LSB  = 8;
  localparam int unsigned STATUS_OVF_BIT = 16;
  localparam int unsigned STATUS_W       = 17;

  function automatic logic [STATUS_W-1:0] pack_status(input logic ovf,
                                                      input logic [7:0] rx_cnt,
                                                      input logic [7:0] tx_cnt);
    logic [STATUS_W-1:0] s;
    s = '0;
    s[STATUS_OVF_BIT]              = ovf;
    s[STATUS_RX_LSB +: 8]          = rx_cnt;
    s[STATUS_TX_LSB +: 8]          = tx_cnt;
    return s;
  endfunction

endpackage

`default_nettype wire

// File: rtl/iob_cnsl_fifo.sv
// +----------------------------------------------------------------------------+
// | iob_cnsl_fifo                                                              |
// | Synchronous FIFO with flush; push and pop may coincide even when full.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module iob_cnsl_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign pop_ok  = pop & ~empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign push_ok = push & (~full | pop_ok);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

endmodule

`default_nettype wire

// File: rtl/iob_cnsl_responder.sv
// +----------------------------------------------------------------------------+
// | iob_cnsl_responder                                                         |
// | Native-bus console register file over TX/RX byte FIFOs.                    |
// | Optional: CNSL_STATUS_EN enables STATUS register and TX overflow flag.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module iob_cnsl_responder
  import iob_cnsl_responder_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 3,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              iob_valid,
  input  logic [ADDR_W-1:0] iob_addr,
  input  logic [DATA_W-1:0] iob_wdata,
  input  logic [3:0]        iob_wstrb,
  output logic [DATA_W-1:0] iob_rdata,
  output logic              iob_ready,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic             is_write;
  logic             tx_push, tx_pop, rx_push, rx_pop, flush;
  logic             tx_full, tx_empty, rx_full, rx_empty;
  logic [7:0]       rx_head;
  logic [CNT_W-1:0] tx_cnt, rx_cnt;
  logic [STATUS_W-1:0] status_word;
  logic [DATA_W-1:0]   rd_next;
  logic                unused_wdata;

  assign is_write = |iob_wstrb;
  assign tx_push  = iob_valid & is_write & iob_wstrb[0] & (iob_addr == ADDR_W'(REG_TXDATA));
  assign rx_pop   = iob_valid & ~is_write & ~rx_empty & (iob_addr == ADDR_W'(REG_RXDATA));
  assign flush    = iob_valid & is_write & iob_wdata[0] & (iob_addr == ADDR_W'(REG_SOFTRESET));
  assign tx_pop   = tx_valid & tx_ready;
  assign rx_push  = rx_valid & rx_ready;
  assign tx_valid = ~tx_empty;
  assign rx_ready = ~rx_full;
  assign unused_wdata = ^iob_wdata[DATA_W-1:8];

  iob_cnsl_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_tx_fifo (
    .clk(clk), .rst(rst), .flush(flush),
    .push(tx_push), .din(iob_wdata[7:0]), .pop(tx_pop), .dout(tx_data),
    .full(tx_full), .empty(tx_empty), .count(tx_cnt)
  );

  iob_cnsl_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_rx_fifo (
    .clk(clk), .rst(rst), .flush(flush),
    .push(rx_push), .din(rx_data), .pop(rx_pop), .dout(rx_head),
    .full(rx_full), .empty(rx_empty), .count(rx_cnt)
  );

`ifdef CNSL_STATUS_EN
  logic tx_ovf;

  // A byte is only lost when the FIFO is full and the stream side frees nothing this cycle.
  always_ff @(posedge clk) begin
    if (rst || flush)                    tx_ovf <= 1'b0;
    else if (tx_push && tx_full && !tx_pop) tx_ovf <= 1'b1;
  end

  assign status_word = pack_status(tx_ovf, 8'(rx_cnt), 8'(tx_cnt));
`else
  logic unused_cnt;
  assign unused_cnt  = ^{tx_cnt, rx_cnt};
  assign status_word = '0;
`endif

  always_comb begin
    rd_next = '0;
    if (!is_write) begin
      case (iob_addr)
        ADDR_W'(REG_RXDATA):  rd_next[7:0] = rx_empty ? 8'h00 : rx_head;
        ADDR_W'(REG_TXREADY): rd_next[0]   = ~tx_full;
        ADDR_W'(REG_RXREADY): rd_next[0]   = ~rx_empty;
        ADDR_W'(REG_STATUS):  rd_next[STATUS_W-1:0] = status_word;
        default:              rd_next = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      iob_ready <= 1'b0;
      iob_rdata <= '0;
    end else begin
      iob_ready <= iob_valid;
      if (iob_valid) iob_rdata <= rd_next;
    end
  end

endmodule

`default_nettype wire
